// File: rtl/frame_tx_packer.sv
// ============================================================================
// Module  : frame_tx_packer (+ crc8_maxim)
// Brief   : Frames a payload byte stream as sync, [seq], payload, CRC8/Maxim.
//           Optional sequence byte enabled by defining FRAME_TX_SEQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_maxim (
  input  logic [7:0] last_crc,
  input  logic [7:0] data,
  output logic [7:0] crc
);
  logic [7:0] c;

  // Reflected polynomial 0x31 (0x8C), one byte per call, LSB first
  always_comb begin
    c = last_crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    crc = c;
  end
endmodule

module frame_tx_packer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef FRAME_TX_SEQ_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEQ     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CRC     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd2,
    S_CRC     = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       m_data_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       crc_in;
  logic [7:0]       crc_next;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             slot_free;
  logic             load;
  logic [7:0]       ld_data;
  logic             ld_last;

`ifdef FRAME_TX_SEQ_EN
  logic [7:0]       seq_q, seq_d;
  assign crc_in = (state_q == S_SEQ) ? seq_q : s_data;
`else
  assign crc_in = s_data;
`endif

  assign slot_free = !m_valid_q || m_ready;

  crc8_maxim u_crc (
    .last_crc (crc_q),
    .data     (crc_in),
    .crc      (crc_next)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    load    = 1'b0;
    ld_data = 8'h00;
    ld_last = 1'b0;
    s_ready = 1'b0;
`ifdef FRAME_TX_SEQ_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Sync byte is emitted without consuming the waiting payload byte
        if (s_valid && slot_free) begin
          load    = 1'b1;
          ld_data = SYNC_BYTE;
`ifdef FRAME_TX_SEQ_EN
          state_d = S_SEQ;
`else
          state_d = S_PAYLOAD;
`endif
        end
      end
`ifdef FRAME_TX_SEQ_EN
      S_SEQ: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = seq_q;
          crc_d   = crc_next;
          state_d = S_PAYLOAD;
        end
      end
`endif
      S_PAYLOAD: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          load    = 1'b1;
          ld_data = s_data;
          crc_d   = crc_next;
          if (s_last) begin
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = crc_q;
          ld_last = 1'b1;
          crc_d   = 8'h00;
`ifdef FRAME_TX_SEQ_EN
          seq_d   = seq_q + 8'd1;
`endif
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      crc_q       <= 8'h00;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FRAME_TX_SEQ_EN
      seq_q       <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
`ifdef FRAME_TX_SEQ_EN
      seq_q   <= seq_d;
`endif
      if (m_valid_q && m_ready && m_last_q) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (slot_free) begin
        m_valid_q <= load;
        m_last_q  <= load && ld_last;
        if (load) begin
          m_data_q <= ld_data;
        end
      end
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire
